// File: rtl/icb_sram_bridge_pkg.sv
// icb_sram_bridge_pkg: shared FSM states, register offsets and STATUS bit positions for the bridge
package icb_sram_bridge_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RD1, ST_RD2, ST_RSP} state_e;
    localparam int CTRL_OFS  = 'h0;
    localparam int STAT_OFS  = 'h4;
    localparam int STAT_DONE = 0;
    localparam int STAT_PERR = 1;
    localparam int STAT_VLD  = 2;
endpackage

// File: rtl/icb_pack_stage.sv
// icb_pack_stage: holds the low half of a pending 64-bit bank word and flags mismatched high halves
// lo_we/hi_we: low/high half bank write accepted; tag: {bank, word} of that write; wdata: ICB data
// clr_err: write-1-to-clear of pack_err; pack_data: word to store on a high-half write
module icb_pack_stage #(
    parameter int TAG_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lo_we,
    input  logic             hi_we,
    input  logic             clr_err,
    input  logic [TAG_W-1:0] tag,
    input  logic [31:0]      wdata,
    output logic [63:0]      pack_data,
    output logic             stage_vld,
    output logic             pack_err
);
    logic [31:0]      stage_lo_q, stage_lo_d;
    logic [TAG_W-1:0] stage_tag_q, stage_tag_d;
    logic             stage_vld_q, stage_vld_d, pack_err_q, pack_err_d, match;
    always_comb begin
        match       = stage_vld_q && (stage_tag_q == tag);
        pack_data   = {wdata, match ? stage_lo_q : 32'h0};
        stage_lo_d  = lo_we ? wdata : stage_lo_q;
        stage_tag_d = lo_we ? tag : stage_tag_q;
        stage_vld_d = lo_we ? 1'b1 : hi_we ? 1'b0 : stage_vld_q;
        // a coincident set beats the clear
        pack_err_d  = (hi_we && !match) || (pack_err_q && !clr_err);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_lo_q  <= '0;
            stage_tag_q <= '0;
            stage_vld_q <= 1'b0;
            pack_err_q  <= 1'b0;
        end else begin
            stage_lo_q  <= stage_lo_d;
            stage_tag_q <= stage_tag_d;
            stage_vld_q <= stage_vld_d;
            pack_err_q  <= pack_err_d;
        end
    end
    assign stage_vld = stage_vld_q;
    assign pack_err  = pack_err_q;
endmodule

// File: rtl/icb_sram_bridge.sv
// icb_sram_bridge: ICB slave packing 32-bit writes into 64-bit bank words, with a result-SRAM read window and CONTROL/STATUS
// icb_cmd_*/icb_rsp_*: single-outstanding ICB slave; sram_*: shared bank write port, per-bank active-low strobe
// out_*: result-SRAM read port (data one cycle after the enable edge); acc_done: live done flag
// control/ctrl_start: CONTROL register and its bit0 one-cycle start pulse
module icb_sram_bridge
    import icb_sram_bridge_pkg::*;
#(
    parameter int NUM_BANKS = 7,
    parameter int WIN_LOG2  = 10,
    parameter int SRAM_AW   = 12,
    localparam int IDX_W    = $clog2(NUM_BANKS + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 icb_cmd_valid,
    output logic                 icb_cmd_ready,
    input  logic                 icb_cmd_read,
    input  logic [31:0]          icb_cmd_addr,
    input  logic [31:0]          icb_cmd_wdata,
    input  logic [3:0]           icb_cmd_wmask,
    output logic                 icb_rsp_valid,
    input  logic                 icb_rsp_ready,
    output logic [31:0]          icb_rsp_rdata,
    output logic                 icb_rsp_err,
    output logic [NUM_BANKS-1:0] sram_wsbn,
    output logic [SRAM_AW-1:0]   sram_waddr,
    output logic [63:0]          sram_wdata,
    output logic                 out_csbn,
    output logic [SRAM_AW-1:0]   out_raddr,
    input  logic [63:0]          out_rdata,
    input  logic                 acc_done,
    output logic [31:0]          control,
    output logic                 ctrl_start
);
    localparam int WW = WIN_LOG2 - 3;
    state_e                state_q, state_d;
    logic [NUM_BANKS-1:0]  wsbn_q, wsbn_d;
    logic [SRAM_AW-1:0]    waddr_q, waddr_d, raddr_q, raddr_d;
    logic [63:0]           wdata_q, wdata_d, pack_data;
    logic [31:0]           control_q, control_d, rsp_rdata_q, rsp_rdata_d, bm, status, reg_rdata;
    logic                  csbn_q, csbn_d, rd_half_q, rd_half_d, ctrl_start_q, ctrl_start_d, rsp_err_q, rsp_err_d;
    logic [IDX_W-1:0]      idx;
    logic [WW-1:0]         word;
    logic [WIN_LOG2-1:0]   ofs;
    logic                  half, accept, is_bank, is_res, is_reg, is_ctrl, is_stat, ok;
    logic                  lo_we, hi_we, res_rd, ctrl_wr, stat_wr, stage_vld, pack_err, addr_unused;
    assign idx         = icb_cmd_addr[WIN_LOG2 +: IDX_W];
    assign word        = icb_cmd_addr[WIN_LOG2-1:3];
    assign half        = icb_cmd_addr[2];
    assign ofs         = icb_cmd_addr[WIN_LOG2-1:0];
    assign addr_unused = ^icb_cmd_addr[31:WIN_LOG2+IDX_W];
    always_comb begin
        accept    = icb_cmd_valid && (state_q == ST_IDLE);
        is_bank   = idx < IDX_W'(NUM_BANKS);
        is_res    = idx == IDX_W'(NUM_BANKS);
        is_reg    = idx == IDX_W'(NUM_BANKS + 1);
        is_ctrl   = is_reg && (ofs == WIN_LOG2'(CTRL_OFS));
        is_stat   = is_reg && (ofs == WIN_LOG2'(STAT_OFS));
        ok        = (is_bank && !icb_cmd_read && icb_cmd_wmask == 4'hF) || (is_res && icb_cmd_read) || is_ctrl || is_stat;
        lo_we     = accept && is_bank && ok && !half;
        hi_we     = accept && is_bank && ok && half;
        res_rd    = accept && is_res && icb_cmd_read;
        ctrl_wr   = accept && is_ctrl && !icb_cmd_read;
        stat_wr   = accept && is_stat && !icb_cmd_read;
        bm        = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}}, {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
        status    = '0;
        status[STAT_DONE] = acc_done;
        status[STAT_PERR] = pack_err;
        status[STAT_VLD]  = stage_vld;
        reg_rdata = is_ctrl ? control_q : status;
        // strobes and the start pulse are rebuilt every cycle so they last exactly one cycle
        wsbn_d       = hi_we ? ~(NUM_BANKS'(1) << idx) : '1;
        waddr_d      = hi_we ? SRAM_AW'(word) : waddr_q;
        wdata_d      = hi_we ? pack_data : wdata_q;
        csbn_d       = !res_rd;
        raddr_d      = res_rd ? SRAM_AW'(word) : raddr_q;
        rd_half_d    = res_rd ? half : rd_half_q;
        control_d    = ctrl_wr ? (((control_q & ~bm) | (icb_cmd_wdata & bm)) & ~32'h1) : control_q;
        ctrl_start_d = ctrl_wr && icb_cmd_wmask[0] && icb_cmd_wdata[0];
        state_d      = state_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d     = res_rd ? ST_RD1 : ST_RSP;
                rsp_err_d   = !ok;
                rsp_rdata_d = (ok && is_reg && icb_cmd_read) ? reg_rdata : 32'h0;
            end
            ST_RD1: state_d = ST_RD2;
            ST_RD2: begin
                state_d     = ST_RSP;
                rsp_rdata_d = rd_half_q ? out_rdata[63:32] : out_rdata[31:0];
            end
            ST_RSP: state_d = icb_rsp_ready ? ST_IDLE : ST_RSP;
            default: state_d = ST_IDLE;
        endcase
    end
    icb_pack_stage #(.TAG_W(IDX_W + WW)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .lo_we     (lo_we),
        .hi_we     (hi_we),
        .clr_err   (stat_wr && icb_cmd_wmask[0] && icb_cmd_wdata[STAT_PERR]),
        .tag       ({idx, word}),
        .wdata     (icb_cmd_wdata),
        .pack_data (pack_data),
        .stage_vld (stage_vld),
        .pack_err  (pack_err)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wsbn_q       <= '1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            csbn_q       <= 1'b1;
            raddr_q      <= '0;
            rd_half_q    <= 1'b0;
            control_q    <= '0;
            ctrl_start_q <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wsbn_q       <= wsbn_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            csbn_q       <= csbn_d;
            raddr_q      <= raddr_d;
            rd_half_q    <= rd_half_d;
            control_q    <= control_d;
            ctrl_start_q <= ctrl_start_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end
    assign icb_cmd_ready = state_q == ST_IDLE;
    assign icb_rsp_valid = state_q == ST_RSP;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign sram_wsbn     = wsbn_q;
    assign sram_waddr    = waddr_q;
    assign sram_wdata    = wdata_q;
    assign out_csbn      = csbn_q;
    assign out_raddr     = raddr_q;
    assign control       = control_q;
    assign ctrl_start    = ctrl_start_q;
endmodule

// File: tb/tb_icb_sram_bridge.sv
// tb_icb_sram_bridge: directed and randomized checks of icb_sram_bridge against a transaction-level model
module tb_icb_sram_bridge;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0, icb_cmd_ready, icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_addr = '0, icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid, icb_rsp_ready = 1'b0, icb_rsp_err;
    logic [31:0] icb_rsp_rdata, control;
    logic [6:0]  sram_wsbn;
    logic [11:0] sram_waddr, out_raddr;
    logic [63:0] sram_wdata, out_rdata = '0;
    logic        out_csbn, acc_done = 1'b0, ctrl_start;
    int          total = 0, bad = 0;
    int          n_str = 0, n_csb = 0, n_start = 0;
    logic [6:0]  l_wsbn;
    logic [11:0] l_waddr;
    logic [63:0] l_wdata;
    logic [63:0] res_mem [0:4095];
    logic        m_vld, m_perr;
    logic [31:0] m_lo, m_ctrl;
    int          m_tag;

    icb_sram_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err(icb_rsp_err), .sram_wsbn(sram_wsbn), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .out_csbn(out_csbn), .out_raddr(out_raddr), .out_rdata(out_rdata), .acc_done(acc_done),
        .control(control), .ctrl_start(ctrl_start)
    );

    always #5 clk = ~clk;

    // result SRAM: data valid only in the cycle after an enabled edge, junk otherwise
    always @(posedge clk) out_rdata <= !out_csbn ? res_mem[out_raddr] : {$urandom, $urandom};

    always @(negedge clk) begin
        if (sram_wsbn != 7'h7F) begin
            n_str++;
            l_wsbn = sram_wsbn;
            l_waddr = sram_waddr;
            l_wdata = sram_wdata;
        end
        if (!out_csbn) n_csb++;
        if (ctrl_start) n_start++;
    end

    task automatic do_reset();
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // one ICB transaction, starting and ending at a negedge; lat counts negedges from accept to rsp_valid
    task automatic txn(input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input int stall, output logic [31:0] rdata, output logic err, output int lat,
                       output logic stable);
        int w = 0;
        while (!icb_cmd_ready && w < 20) begin @(negedge clk); w++; end
        icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = a; icb_cmd_wdata = d; icb_cmd_wmask = m;
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (icb_rsp_valid) begin lat = i; break; end
        end
        rdata = icb_rsp_rdata;
        err = icb_rsp_err;
        stable = 1'b1;
        if (lat < 0) return;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!icb_rsp_valid || icb_rsp_rdata !== rdata || icb_rsp_err !== err || icb_cmd_ready) stable = 1'b0;
        end
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1 icb_rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({sram_wsbn, out_csbn} !== 8'hFF) begin bad++; $display("FAIL reset_strobes got=%h exp=ff", {sram_wsbn, out_csbn}); end
        total++; if ({sram_waddr, sram_wdata, out_raddr} !== '0) begin bad++; $display("FAIL reset_addr_data got=%h/%h/%h exp=0", sram_waddr, sram_wdata, out_raddr); end
        total++; if ({control, ctrl_start} !== '0) begin bad++; $display("FAIL reset_control got=%h/%b exp=0", control, ctrl_start); end
        total++; if ({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata} !== '0) begin bad++; $display("FAIL reset_rsp got=%b/%b/%h exp=0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", icb_cmd_ready); end
    endtask

    task automatic test_pack();
        logic [31:0] rd; logic err, st; int lat, s0;
        s0 = n_str;
        txn(1'b0, 32'h800, 32'h1100_0011, 4'hF, 0, rd, err, lat, st);
        total++; if (n_str != s0) begin bad++; $display("FAIL pack_lo_no_strobe got=%0d exp=0", n_str - s0); end
        txn(1'b0, 32'h804, 32'h0000_1111, 4'hF, 0, rd, err, lat, st);
        total++; if (n_str - s0 != 1) begin bad++; $display("FAIL pack_strobe_cycles got=%0d exp=1", n_str - s0); end
        total++; if (l_wsbn !== 7'b1111011) begin bad++; $display("FAIL pack_wsbn got=%b exp=1111011", l_wsbn); end
        total++; if (l_waddr !== 12'h0) begin bad++; $display("FAIL pack_waddr got=%h exp=0", l_waddr); end
        total++; if (l_wdata !== 64'h0000_1111_1100_0011) begin bad++; $display("FAIL pack_wdata got=%h exp=0000111111000011", l_wdata); end
        total++; if (err !== 1'b0 || lat != 1) begin bad++; $display("FAIL pack_rsp got err=%b lat=%0d exp err=0 lat=1", err, lat); end
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL pack_status got=%h exp=0", rd); end
    endtask

    task automatic test_pack_err();
        logic [31:0] rd; logic err, st; int lat;
        txn(1'b0, 32'h80C, 32'hCAFE_0001, 4'hF, 0, rd, err, lat, st);
        total++; if (l_wdata !== 64'hCAFE_0001_0000_0000 || l_waddr !== 12'h1) begin bad++; $display("FAIL orphan_hi_write got=%h@%h exp=cafe000100000000@001", l_wdata, l_waddr); end
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL pack_err_set got=%h exp=2", rd); end
        txn(1'b0, 32'h2004, 32'h2, 4'hF, 0, rd, err, lat, st);
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL pack_err_clear got=%h exp=0", rd); end
    endtask

    task automatic test_result_read();
        logic [31:0] rd; logic err, st; int lat, c0;
        res_mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        c0 = n_csb;
        txn(1'b1, 32'h1C04, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'hAAAA_BBBB) begin bad++; $display("FAIL result_hi got=%h exp=aaaabbbb", rd); end
        total++; if (lat != 3) begin bad++; $display("FAIL result_latency got=%0d exp=3", lat); end
        total++; if (n_csb - c0 != 1) begin bad++; $display("FAIL result_csbn_cycles got=%0d exp=1", n_csb - c0); end
        txn(1'b1, 32'h1C00, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'hCCCC_DDDD || err !== 1'b0) begin bad++; $display("FAIL result_lo got=%h err=%b exp=ccccdddd err=0", rd, err); end
    endtask

    task automatic test_control();
        logic [31:0] rd; logic err, st; int lat, t0;
        t0 = n_start;
        txn(1'b0, 32'h2000, 32'h0000_0005, 4'hF, 0, rd, err, lat, st);
        total++; if (n_start - t0 != 1) begin bad++; $display("FAIL start_pulse_cycles got=%0d exp=1", n_start - t0); end
        total++; if (control !== 32'h4) begin bad++; $display("FAIL control_out got=%h exp=4", control); end
        txn(1'b1, 32'h2000, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL control_read got=%h exp=4", rd); end
        txn(1'b0, 32'h2000, 32'hFFFF_FFFF, 4'b0010, 0, rd, err, lat, st);
        total++; if (control !== 32'h0000_FF04 || n_start - t0 != 1) begin bad++; $display("FAIL control_bytemask got=%h starts=%0d exp=0000ff04 starts=1", control, n_start - t0); end
    endtask

    task automatic test_errors();
        logic [31:0] ad [4] = '{32'h0800, 32'h1C00, 32'h2400, 32'h0800};
        logic        rdv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  mk [4] = '{4'hF, 4'hF, 4'hF, 4'h3};
        logic [31:0] rd; logic err, st; int lat, s0, c0, t0;
        for (int i = 0; i < 4; i++) begin
            s0 = n_str; c0 = n_csb; t0 = n_start;
            txn(rdv[i], ad[i], 32'hFFFF_FFFF, mk[i], 5, rd, err, lat, st);
            total++; if (err !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_rsp[%0d] got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=1", i, err, rd, lat); end
            total++; if (n_str != s0 || n_csb != c0 || n_start != t0) begin bad++; $display("FAIL err_side_effect[%0d] got str=%0d csb=%0d start=%0d exp=0", i, n_str - s0, n_csb - c0, n_start - t0); end
            total++; if (st !== 1'b1) begin bad++; $display("FAIL err_stall_stable[%0d] got=%b exp=1", i, st); end
        end
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_no_stage got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, st; int lat, s0;
        s0 = n_str;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h804; icb_cmd_wdata = 32'h1; icb_cmd_wmask = 4'hF;
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (sram_wsbn !== 7'h7F || icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_abort got wsbn=%b rsp_valid=%b exp wsbn=1111111 rsp_valid=0", sram_wsbn, icb_rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (n_str != s0 || icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_abort_after got str=%0d rsp_valid=%b exp=0/0", n_str - s0, icb_rsp_valid); end
        txn(1'b0, 32'h800, 32'h1234_5678, 4'hF, 0, rd, err, lat, st);
        do_reset();
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", rd); end
        txn(1'b0, 32'h804, 32'h9ABC_DEF0, 4'hF, 0, rd, err, lat, st);
        total++; if (l_wdata !== 64'h9ABC_DEF0_0000_0000) begin bad++; $display("FAIL reset_stage_lost got=%h exp=9abcdef000000000", l_wdata); end
        txn(1'b1, 32'h2004, 32'h0, 4'hF, 0, rd, err, lat, st);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL reset_pack_err got=%h exp=2", rd); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, e_rd; logic r, err, e_err, st; logic [3:0] m; logic [63:0] e_wd;
        int lat, e_lat, e_str, e_csb, e_start, s0, c0, t0, idx, word, half, ofs;
        do_reset();
        m_vld = 1'b0; m_perr = 1'b0; m_ctrl = '0; m_lo = '0; m_tag = 0;
        for (int n = 0; n < 250; n++) begin
            idx = $urandom_range(0, 11); word = $urandom_range(0, 3); half = $urandom_range(0, 1);
            r = 1'($urandom_range(0, 1)); d = $urandom;
            m = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            a = ($urandom & 32'hFFFF_C000) | 32'(idx * 1024 + word * 8 + half * 4);
            ofs = word * 8 + half * 4;
            acc_done = 1'($urandom_range(0, 1));
            e_err = 1'b0; e_rd = '0; e_lat = 1; e_str = 0; e_csb = 0; e_start = 0; e_wd = '0;
            if (idx < 7) begin
                if (r || m != 4'hF) e_err = 1'b1;
                else if (half == 0) begin m_vld = 1'b1; m_lo = d; m_tag = idx * 128 + word; end
                else begin
                    e_str = 1;
                    e_wd = {d, (m_vld && m_tag == idx * 128 + word) ? m_lo : 32'h0};
                    if (!(m_vld && m_tag == idx * 128 + word)) m_perr = 1'b1;
                    m_vld = 1'b0;
                end
            end else if (idx == 7) begin
                if (!r) e_err = 1'b1;
                else begin e_lat = 3; e_csb = 1; e_rd = half ? res_mem[word][63:32] : res_mem[word][31:0]; end
            end else if (idx == 8 && ofs == 0) begin
                if (r) e_rd = m_ctrl;
                else begin
                    for (int b = 0; b < 4; b++) if (m[b]) m_ctrl[8*b +: 8] = d[8*b +: 8];
                    m_ctrl[0] = 1'b0;
                    e_start = (m[0] && d[0]) ? 1 : 0;
                end
            end else if (idx == 8 && ofs == 4) begin
                if (r) e_rd = {29'h0, m_vld, m_perr, acc_done};
                else if (m[0] && d[1]) m_perr = 1'b0;
            end else e_err = 1'b1;
            s0 = n_str; c0 = n_csb; t0 = n_start;
            txn(r, a, d, m, $urandom_range(0, 2), rd, err, lat, st);
            total++; if (err !== e_err || lat != e_lat) begin bad++; $display("FAIL rnd_rsp[%0d] a=%h got err=%b lat=%0d exp err=%b lat=%0d", n, a, err, lat, e_err, e_lat); end
            if (r || e_err) begin
                total++; if (rd !== e_rd) begin bad++; $display("FAIL rnd_rdata[%0d] a=%h got=%h exp=%h", n, a, rd, e_rd); end
            end
            total++; if (n_str - s0 != e_str || n_csb - c0 != e_csb || n_start - t0 != e_start) begin bad++; $display("FAIL rnd_pulses[%0d] a=%h got str=%0d csb=%0d start=%0d exp %0d/%0d/%0d", n, a, n_str - s0, n_csb - c0, n_start - t0, e_str, e_csb, e_start); end
            if (e_str == 1) begin
                total++; if (l_wsbn !== 7'(~(7'd1 << idx)) || l_waddr !== 12'(word) || l_wdata !== e_wd) begin bad++; $display("FAIL rnd_bank_write[%0d] a=%h got %b/%h/%h exp %b/%h/%h", n, a, l_wsbn, l_waddr, l_wdata, 7'(~(7'd1 << idx)), 12'(word), e_wd); end
            end
            total++; if (control !== m_ctrl) begin bad++; $display("FAIL rnd_control[%0d] got=%h exp=%h", n, control, m_ctrl); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) res_mem[i] = {$urandom, $urandom};
        test_reset();
        test_pack();
        test_pack_err();
        test_result_read();
        test_control();
        test_errors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
